softmax_seq_ctrl: RTL and testbench
===================================

Name: softmax_seq_ctrl

Overview:
Vector-level sequencer for softmax over signed Q16.16 fixed-point vectors of up to MAX_LEN elements. It buffers one input vector and tracks the running maximum. It then drives an external exponent engine with (x - max) and accumulates the sum of results, and finally drives an external divider to normalise each exponent by the sum. It sits between the AI load/store stream and the shared exp/div arithmetic units, and holds each unit to one outstanding request at a time.

Parameters:
DATA_W, 32, element width, signed Q16.16 on input, unsigned Q16.16 on exp/div results
MAX_LEN, 16, maximum vector length, power of two, at least 2
ACC_W, 40, width of the unsigned exponent-sum accumulator

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  input element valid
in_ready  out  1  controller accepts input element
in_data  in  DATA_W  signed Q16.16 element
in_last  in  1  final element of the vector
exp_req_valid  out  1  exponent request valid
exp_req_ready  in  1  exponent unit accepts request
exp_req_data  out  DATA_W  saturated (x - max), always <= 0
exp_rsp_valid  in  1  exponent result valid, one cycle pulse
exp_rsp_data  in  DATA_W  exp result, unsigned Q16.16
div_req_valid  out  1  divide request valid
div_req_ready  in  1  divider accepts request
div_num  out  ACC_W  numerator, zero-extended exp value
div_den  out  ACC_W  denominator, the exponent sum
div_rsp_valid  in  1  quotient valid, one cycle pulse
div_rsp_data  in  DATA_W  quotient, unsigned Q16.16
out_valid  out  1  softmax result valid
out_ready  in  1  downstream accepts result
out_data  out  DATA_W  softmax result, Q16.16
out_last  out  1  final result of the vector
busy  out  1  high in any state other than IDLE
len_err  out  1  sticky: a vector was truncated at MAX_LEN; cleared only by reset

Behaviour:
- Reset, asynchronous on rst low:
  - state = IDLE.
  - All valids, busy, len_err, out_last = 0; out_data = 0.
  - Counters, max and sum are cleared.
  - Reset mid-operation abandons the vector. An in-flight exp or div response arriving after reset release is ignored.
- IDLE: in_ready = 1. The first handshake stores the element in buf[0], sets max = in_data and count = 1, then moves to LOAD. If that element carries in_last, go directly to EXP.
- LOAD: in_ready = 1.
  - Each handshake writes buf[count] and updates max with a signed compare (ties keep the old value), then increments count.
  - in_last moves to EXP.
  - At count = MAX_LEN-1 the accepted element is treated as last regardless of in_last; len_err is set if in_last was 0.
- EXP: in_ready = 0. Idx runs 0..count-1.
  - exp_req_data = buf[idx] - max, computed at DATA_W+1 bits and saturated to the most negative DATA_W value.
  - exp_req_valid holds until exp_req_ready. No new request is issued until exp_rsp_valid.
  - On response: buf[idx] = exp_rsp_data; sum += zero-extended exp_rsp_data, saturating at 2^ACC_W-1.
  - After the last response go to NORM with idx = 0.
- NORM: div_den = sum, div_num = buf[idx]. A request is issued only when the output register is empty.
  - The quotient loads out_data, out_valid = 1, and out_last = (idx == count-1).
  - Data is held stable until out_ready. The next div request goes out in the cycle after the handshake.
  - The handshake on out_last returns to IDLE.
  - If sum == 0: no div requests are issued; each output is 0x00000000 with the same handshake and out_last rules.
- out_valid must never drop without a handshake. exp/div request signals must stay stable while valid and not ready.
- Minimum latency, with exp/div ready and a 1-cycle response: first output 2 cycles after NORM entry.

Optional Feature:
SOFTMAX_CTRL_STATS_EN:
- When defined, adds two outputs:
  - stat_vectors [31:0]: count of completed vectors, incremented on the out_last handshake, wrapping.
  - stat_cycles [31:0]: cycles from the first input handshake to the out_last handshake of the most recent vector, saturating.
- Both reset to 0.
- When not defined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Single element 0x00030000 with in_last → exp_req_data 0x00000000; model exp = 0x00010000; div_num = div_den = 0x10000; out_data 0x00010000, out_last = 1.
- Vector [0x00010000, 0x00010000] → both exp reqs 0; sum 0x20000; outputs 0x00008000, 0x00008000; out_last on the second only.
- Vector [0x7FFFFFFF, 0x80000000] → second exp_req_data saturates to 0x80000000; model exp returns 0; outputs 0x00010000 then 0x00000000.
- MAX_LEN+2 elements with no in_last → only MAX_LEN accepted; len_err = 1; in_ready = 0 until IDLE. The next vector processes normally with len_err still 1.
- Exp unit returns 0 for all 3 elements → no div_req_valid asserted; three 0x00000000 outputs.
- out_ready held low for 5 cycles mid-vector, plus rst pulsed low during EXP → out_data stable while stalled; after reset all outputs are 0, state is IDLE, and a late exp_rsp_valid has no effect.

Source files
------------

// File: rtl/softmax_seq_ctrl.sv
// Softmax vector sequencer: buffers a signed Q16.16 vector, then drives the exp and div units
// one request at a time. Define SOFTMAX_CTRL_STATS_EN to add stat_vectors/stat_cycles outputs.
module softmax_seq_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned ACC_W   = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              exp_req_valid,
  input  logic              exp_req_ready,
  output logic [DATA_W-1:0] exp_req_data,
  input  logic              exp_rsp_valid,
  input  logic [DATA_W-1:0] exp_rsp_data,
  output logic              div_req_valid,
  input  logic              div_req_ready,
  output logic [ACC_W-1:0]  div_num,
  output logic [ACC_W-1:0]  div_den,
  input  logic              div_rsp_valid,
  input  logic [DATA_W-1:0] div_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              len_err
`ifdef SOFTMAX_CTRL_STATS_EN
  ,
  output logic [31:0]       stat_vectors,
  output logic [31:0]       stat_cycles
`endif
);

  localparam int unsigned IdxW = $clog2(MAX_LEN);
  localparam int unsigned CntW = IdxW + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StExp, StNorm} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q [MAX_LEN];
  logic [CntW-1:0]   count_q, count_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic              exp_req_valid_q, exp_req_valid_d;
  logic              exp_wait_q, exp_wait_d;
  logic              div_req_valid_q, div_req_valid_d;
  logic              div_wait_q, div_wait_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              len_err_q, len_err_d;

  logic              wr_en;
  logic [IdxW-1:0]   wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              in_hs, out_hs, idx_last;
  logic [DATA_W:0]   diff;
  logic [ACC_W:0]    sum_ext;
  logic [ACC_W-1:0]  sum_sat;

  assign in_ready = (state_q == StIdle) || (state_q == StLoad);
  assign busy     = (state_q != StIdle);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;
  assign idx_last = ({1'b0, idx_q} + CntW'(1)) == count_q;

  // x - max at DATA_W+1 bits; the result is never positive, so only underflow can occur.
  assign diff = {data_q[idx_q][DATA_W-1], data_q[idx_q]} - {max_q[DATA_W-1], max_q};
  assign exp_req_data = (diff[DATA_W] ^ diff[DATA_W-1]) ? {1'b1, {(DATA_W-1){1'b0}}}
                                                         : diff[DATA_W-1:0];

  assign sum_ext = {1'b0, sum_q} + {{(ACC_W+1-DATA_W){1'b0}}, exp_rsp_data};
  assign sum_sat = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

  assign exp_req_valid = exp_req_valid_q;
  assign div_req_valid = div_req_valid_q;
  assign div_num       = {{(ACC_W-DATA_W){1'b0}}, data_q[idx_q]};
  assign div_den       = sum_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign len_err       = len_err_q;

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    idx_d           = idx_q;
    max_d           = max_q;
    sum_d           = sum_q;
    exp_req_valid_d = exp_req_valid_q;
    exp_wait_d      = exp_wait_q;
    div_req_valid_d = div_req_valid_q;
    div_wait_d      = div_wait_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_last_d      = out_last_q;
    len_err_d       = len_err_q;
    wr_en           = 1'b0;
    wr_idx          = idx_q;
    wr_data         = in_data;
    unique case (state_q)
      StIdle: begin
        if (in_hs) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          max_d   = in_data;
          count_d = CntW'(1);
          idx_d   = '0;
          sum_d   = '0;
          if (in_last) begin
            state_d         = StExp;
            exp_req_valid_d = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (in_hs) begin
          wr_en   = 1'b1;
          wr_idx  = count_q[IdxW-1:0];
          count_d = count_q + CntW'(1);
          if ($signed(in_data) > $signed(max_q)) max_d = in_data;
          // The buffer is full after this element, so it closes the vector either way.
          if (in_last || (count_q == CntW'(MAX_LEN - 1))) begin
            state_d         = StExp;
            idx_d           = '0;
            exp_req_valid_d = 1'b1;
            if (!in_last) len_err_d = 1'b1;
          end
        end
      end
      StExp: begin
        if (exp_req_valid_q && exp_req_ready) begin
          exp_req_valid_d = 1'b0;
          exp_wait_d      = 1'b1;
        end
        if (exp_wait_q && exp_rsp_valid) begin
          exp_wait_d = 1'b0;
          wr_en      = 1'b1;
          wr_idx     = idx_q;
          wr_data    = exp_rsp_data;
          sum_d      = sum_sat;
          if (idx_last) begin
            state_d         = StNorm;
            idx_d           = '0;
            div_req_valid_d = (sum_sat != '0);
          end else begin
            idx_d           = idx_q + IdxW'(1);
            exp_req_valid_d = 1'b1;
          end
        end
      end
      StNorm: begin
        if (div_req_valid_q && div_req_ready) begin
          div_req_valid_d = 1'b0;
          div_wait_d      = 1'b1;
        end
        if (div_wait_q && div_rsp_valid) begin
          div_wait_d  = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = div_rsp_data;
          out_last_d  = idx_last;
        end else if (!out_valid_q && (sum_q == '0)) begin
          out_valid_d = 1'b1;
          out_data_d  = '0;
          out_last_d  = idx_last;
        end
        if (out_hs) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = StIdle;
            count_d = '0;
            idx_d   = '0;
            max_d   = '0;
            sum_d   = '0;
          end else begin
            idx_d           = idx_q + IdxW'(1);
            div_req_valid_d = (sum_q != '0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      count_q         <= '0;
      idx_q           <= '0;
      max_q           <= '0;
      sum_q           <= '0;
      exp_req_valid_q <= 1'b0;
      exp_wait_q      <= 1'b0;
      div_req_valid_q <= 1'b0;
      div_wait_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_last_q      <= 1'b0;
      len_err_q       <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) data_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      idx_q           <= idx_d;
      max_q           <= max_d;
      sum_q           <= sum_d;
      exp_req_valid_q <= exp_req_valid_d;
      exp_wait_q      <= exp_wait_d;
      div_req_valid_q <= div_req_valid_d;
      div_wait_q      <= div_wait_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_last_q      <= out_last_d;
      len_err_q       <= len_err_d;
      if (wr_en) data_q[wr_idx] <= wr_data;
    end
  end

`ifdef SOFTMAX_CTRL_STATS_EN
  logic [31:0] stat_vectors_q, stat_vectors_d;
  logic [31:0] stat_cycles_q, stat_cycles_d;
  logic [31:0] run_cnt_q, run_cnt_d;

  always_comb begin
    stat_vectors_d = stat_vectors_q;
    stat_cycles_d  = stat_cycles_q;
    run_cnt_d      = run_cnt_q;
    if ((state_q == StIdle) && in_hs) begin
      run_cnt_d = 32'd1;
    end else if (busy && (run_cnt_q != '1)) begin
      run_cnt_d = run_cnt_q + 32'd1;
    end
    if ((state_q == StNorm) && out_hs && out_last_q) begin
      stat_vectors_d = stat_vectors_q + 32'd1;
      stat_cycles_d  = run_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_vectors_q <= '0;
      stat_cycles_q  <= '0;
      run_cnt_q      <= '0;
    end else begin
      stat_vectors_q <= stat_vectors_d;
      stat_cycles_q  <= stat_cycles_d;
      run_cnt_q      <= run_cnt_d;
    end
  end

  assign stat_vectors = stat_vectors_q;
  assign stat_cycles  = stat_cycles_q;
`endif

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Bench for softmax_seq_ctrl: the bench plays the exp and div units and checks every request and
// result against a vector-level softmax model computed from the input vector.
module tb_softmax_seq_ctrl;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned ACC_W   = 40;
  localparam longint      MinV    = -(longint'(1) << 31);
  localparam longint      MaxAcc  = (longint'(1) << 40) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              exp_req_valid;
  logic              exp_req_ready = 1'b0;
  logic [DATA_W-1:0] exp_req_data;
  logic              exp_rsp_valid = 1'b0;
  logic [DATA_W-1:0] exp_rsp_data = '0;
  logic              div_req_valid;
  logic              div_req_ready = 1'b0;
  logic [ACC_W-1:0]  div_num, div_den;
  logic              div_rsp_valid = 1'b0;
  logic [DATA_W-1:0] div_rsp_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              len_err;

  int checks = 0;
  int failures = 0;

  softmax_seq_ctrl #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .exp_req_valid(exp_req_valid), .exp_req_ready(exp_req_ready), .exp_req_data(exp_req_data),
    .exp_rsp_valid(exp_rsp_valid), .exp_rsp_data(exp_rsp_data),
    .div_req_valid(div_req_valid), .div_req_ready(div_req_ready), .div_num(div_num),
    .div_den(div_den), .div_rsp_valid(div_rsp_valid), .div_rsp_data(div_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Stand-in exp unit: 1.0 halved per whole unit below zero, plus a small fractional term.
  function automatic logic [31:0] exp_fn(input logic [31:0] d);
    longint nd, sh;
    logic [31:0] e;
    nd = -longint'($signed(d));
    sh = nd >>> 16;
    e = (sh >= 17) ? 32'h0 : (32'h10000 >> sh);
    return e + 32'(nd & 63);
  endfunction

  // Knobs and observation queues shared with the unit models.
  int  exp_fix = -1;
  bit  exp_zero = 1'b0;
  bit  stab_en = 1'b1;
  bit  out_hold = 1'b0;
  bit  div_seen = 1'b0;
  logic [31:0] obs_exp[$];
  logic [39:0] obs_num[$], obs_den[$];
  logic [31:0] got_data[$];
  logic        got_last[$];

  // Exp unit
  bit ep = 1'b0;
  int ec = 0;
  logic [31:0] ev = '0, pd_e = '0;
  logic pv_e = 1'b0, pr_e = 1'b0;
  always @(negedge clk) begin
    exp_rsp_valid = 1'b0;
    if (ep) begin
      if (ec == 0) begin
        exp_rsp_valid = 1'b1;
        exp_rsp_data  = ev;
        ep = 1'b0;
      end else ec--;
    end
    if (stab_en && pv_e && !pr_e) begin
      chk("exp_req_valid_held", exp_req_valid, 1);
      chk("exp_req_data_held", exp_req_data, pd_e);
    end
    exp_req_ready = ($urandom_range(0, 2) != 0);
    if (exp_req_valid && exp_req_ready) begin
      obs_exp.push_back(exp_req_data);
      ev = exp_zero ? 32'h0 : exp_fn(exp_req_data);
      ep = 1'b1;
      ec = (exp_fix >= 0) ? exp_fix : int'($urandom_range(0, 2));
    end
    pv_e = exp_req_valid; pr_e = exp_req_ready; pd_e = exp_req_data;
  end

  // Div unit
  bit dp = 1'b0;
  int dc = 0;
  logic [31:0] dv = '0;
  logic [39:0] pn_d = '0, pdn_d = '0;
  logic pv_d = 1'b0, pr_d = 1'b0;
  logic [63:0] n64;
  always @(negedge clk) begin
    div_rsp_valid = 1'b0;
    if (dp) begin
      if (dc == 0) begin
        div_rsp_valid = 1'b1;
        div_rsp_data  = dv;
        dp = 1'b0;
      end else dc--;
    end
    if (div_req_valid) div_seen = 1'b1;
    if (stab_en && pv_d && !pr_d) begin
      chk("div_req_valid_held", div_req_valid, 1);
      chk("div_num_held", div_num, pn_d);
      chk("div_den_held", div_den, pdn_d);
    end
    div_req_ready = ($urandom_range(0, 2) != 0);
    if (div_req_valid && div_req_ready) begin
      obs_num.push_back(div_num);
      obs_den.push_back(div_den);
      n64 = 64'(div_num) << 16;
      dv = (div_den == 0) ? 32'hDEADBEEF : 32'(n64 / 64'(div_den));
      dp = 1'b1;
      dc = int'($urandom_range(0, 2));
    end
    pv_d = div_req_valid; pr_d = div_req_ready; pn_d = div_num; pdn_d = div_den;
  end

  // Output sink
  logic pov = 1'b0, por = 1'b0, pol = 1'b0;
  logic [31:0] pod = '0;
  always @(negedge clk) begin
    if (stab_en && pov && !por) begin
      chk("out_valid_held", out_valid, 1);
      chk("out_data_held", out_data, pod);
      chk("out_last_held", out_last, pol);
    end
    out_ready = !out_hold && ($urandom_range(0, 3) != 0);
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
    pov = out_valid; por = out_ready; pod = out_data; pol = out_last;
  end

  // Reference model: the whole softmax pass over one (already truncated) vector.
  logic [31:0] e_exp[$], e_out[$];
  logic [39:0] e_num[$];
  logic [39:0] e_den;
  task automatic model(input logic [31:0] v[$], input bit zero);
    longint mx, dl, s;
    logic [31:0] e[$];
    e_exp.delete(); e_out.delete(); e_num.delete();
    mx = longint'($signed(v[0]));
    foreach (v[i]) if (longint'($signed(v[i])) > mx) mx = longint'($signed(v[i]));
    s = 0;
    foreach (v[i]) begin
      dl = longint'($signed(v[i])) - mx;
      if (dl < MinV) dl = MinV;
      e_exp.push_back(32'(dl));
      e.push_back(zero ? 32'h0 : exp_fn(32'(dl)));
      s = s + longint'(e[i]);
      if (s > MaxAcc) s = MaxAcc;
    end
    e_den = 40'(s);
    foreach (e[i]) begin
      if (s != 0) e_num.push_back(40'(e[i]));
      e_out.push_back((s == 0) ? 32'h0 : 32'((longint'(e[i]) << 16) / s));
    end
  endtask

  task automatic clr();
    obs_exp.delete(); obs_num.delete(); obs_den.delete();
    got_data.delete(); got_last.delete();
    div_seen = 1'b0;
  endtask

  task automatic send_vec(input logic [31:0] v[$], input bit with_last);
    int i = 0;
    int g = 0;
    while (i < v.size() && g < 2000) begin
      @(negedge clk);
      g++;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = v[i];
      in_last  = with_last && (i == v.size() - 1);
      if (in_valid && in_ready) i++;
    end
    chk("send_accepted", i, v.size());
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int g = 0;
    while ((got_data.size() < n || busy) && g < 4000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_in_time", g < 4000, 1);
  endtask

  task automatic compare(input string name);
    chk({name, " exp_req_count"}, obs_exp.size(), e_exp.size());
    foreach (e_exp[i])
      if (i < obs_exp.size()) chk($sformatf("%s exp_req[%0d]", name, i), obs_exp[i], e_exp[i]);
    chk({name, " div_req_count"}, obs_num.size(), e_num.size());
    foreach (e_num[i])
      if (i < obs_num.size()) begin
        chk($sformatf("%s div_num[%0d]", name, i), obs_num[i], e_num[i]);
        chk($sformatf("%s div_den[%0d]", name, i), obs_den[i], e_den);
      end
    chk({name, " out_count"}, got_data.size(), e_out.size());
    foreach (e_out[i])
      if (i < got_data.size()) begin
        chk($sformatf("%s out_data[%0d]", name, i), got_data[i], e_out[i]);
        chk($sformatf("%s out_last[%0d]", name, i), got_last[i], i == e_out.size() - 1);
      end
  endtask

  task automatic run_vec(input string name, input logic [31:0] v[$]);
    clr();
    model(v, exp_zero);
    send_vec(v, 1'b1);
    wait_done(v.size());
    compare(name);
  endtask

  logic [31:0] vq[$], vt[$];
  task automatic gen(input int n);
    vq.delete();
    for (int i = 0; i < n; i++)
      vq.push_back(($urandom_range(0, 3) == 0) ? $urandom()
                                               : 32'($urandom_range(0, 32'h60000)) - 32'h30000);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, " exp_req_valid"}, exp_req_valid, 0);
    chk({name, " div_req_valid"}, div_req_valid, 0);
    chk({name, " out_valid"}, out_valid, 0);
    chk({name, " out_data"}, out_data, 0);
    chk({name, " out_last"}, out_last, 0);
    chk({name, " busy"}, busy, 0);
    chk({name, " len_err"}, len_err, 0);
    chk({name, " in_ready"}, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [31:0] cap;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    vt = '{32'h00030000};
    run_vec("single", vt);
    if (got_data.size() > 0) chk("single out_const", got_data[0], 32'h00010000);
    if (obs_num.size() > 0) chk("single div_num_const", obs_num[0], 40'h10000);

    vt = '{32'h00010000, 32'h00010000};
    run_vec("pair", vt);
    if (got_data.size() > 1) chk("pair out1_const", got_data[1], 32'h00008000);

    vt = '{32'h7FFFFFFF, 32'h80000000};
    run_vec("extreme", vt);
    if (obs_exp.size() > 1) chk("extreme sat_const", obs_exp[1], 32'h80000000);
    if (got_data.size() > 1) chk("extreme out1_const", got_data[1], 32'h0);

    // Over-long vector without in_last: truncated at MAX_LEN.
    chk("len_err_before", len_err, 0);
    clr();
    gen(MAX_LEN + 2);
    vt = vq[0:MAX_LEN-1];
    model(vt, 1'b0);
    send_vec(vt, 1'b0);
    in_valid = 1'b1;
    in_data  = vq[MAX_LEN];
    g = 0;
    while (g < 4000) begin
      @(negedge clk);
      g++;
      if (!busy) break;
      chk("trunc in_ready", in_ready, 0);
      in_data = vq[MAX_LEN + 1];
    end
    in_valid = 1'b0;
    chk("trunc finished", g < 4000, 1);
    wait_done(MAX_LEN);
    compare("trunc");
    chk("len_err_after", len_err, 1);

    gen(5);
    run_vec("post_trunc", vq);
    chk("len_err_sticky", len_err, 1);

    exp_zero = 1'b1;
    gen(3);
    run_vec("zero_sum", vq);
    chk("zero_sum no_div_valid", div_seen, 0);
    exp_zero = 1'b0;

    // Stall the output register mid-vector.
    clr();
    gen(6);
    model(vq, 1'b0);
    send_vec(vq, 1'b1);
    g = 0;
    while (got_data.size() < 1 && g < 2000) begin @(negedge clk); g++; end
    out_hold = 1'b1;
    while (!out_valid && g < 2000) begin @(negedge clk); g++; end
    chk("stall reached", g < 2000, 1);
    cap = out_data;
    repeat (5) begin
      @(negedge clk);
      chk("stall out_valid", out_valid, 1);
      chk("stall out_data", out_data, cap);
    end
    out_hold = 1'b0;
    wait_done(6);
    compare("stall");

    // Reset during EXP with a response still in flight.
    clr();
    exp_fix = 4;
    gen(3);
    send_vec(vq, 1'b1);
    g = 0;
    while (obs_exp.size() < 1 && g < 2000) begin @(negedge clk); g++; end
    chk("rst exp_req_seen", g < 2000, 1);
    @(negedge clk);
    stab_en = 1'b0;
    rst = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("late_rsp delivered", ep, 0);
    check_idle_outputs("after_late_rsp");
    exp_fix = -1;
    stab_en = 1'b1;

    for (int k = 0; k < 10; k++) begin
      gen(int'($urandom_range(1, MAX_LEN)));
      run_vec($sformatf("rand%0d", k), vq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
